// File: rtl/ttl_hex_debounce.sv
// Six-channel synchroniser + stability-counter debouncer with clean level and edge strobes.
// Optional macro TTL_TIMING_EN adds 74LS-style min:typ:max delays on the outputs.
module ttl_hex_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [5:0] A,
    output logic [5:0] Q,
    output logic [5:0] RISE,
    output logic [5:0] FALL,
    output logic       ANY
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [5:0]       r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt  [6];
    logic [5:0]       r_q;
    logic [5:0]       r_rise;
    logic [5:0]       r_fall;
    logic             r_any;

    logic [5:0]       w_s;
    logic [CNT_W-1:0] w_cnt_nxt [6];
    logic [5:0]       w_q_nxt;
    logic [5:0]       w_rise_nxt;
    logic [5:0]       w_fall_nxt;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= A;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    // Counter only advances while S disagrees with Q, so it tops out at CNT_LAST and never wraps.
    always_comb begin
        w_q_nxt    = r_q;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < 6; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_s[i] != r_q[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_q_nxt[i]    = w_s[i];
                    w_rise_nxt[i] = w_s[i];
                    w_fall_nxt[i] = ~w_s[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
            r_q    <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_q    <= w_q_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_any  <= |(w_rise_nxt | w_fall_nxt);
        end
    end

`ifdef TTL_TIMING_EN
    assign #(0:9:15, 0:10:15) Q    = r_q;
    assign #(0:9:15, 0:10:15) RISE = r_rise;
    assign #(0:9:15, 0:10:15) FALL = r_fall;
    assign #(0:9:15, 0:10:15) ANY  = r_any;
`else
    assign Q    = r_q;
    assign RISE = r_rise;
    assign FALL = r_fall;
    assign ANY  = r_any;
`endif

endmodule

// File: tb/tb_ttl_hex_debounce.sv
// Directed bench for ttl_hex_debounce: default build plus two parameter variants on shared inputs.
module tb_ttl_hex_debounce;
    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic [5:0] A   = 6'h00;

    logic [5:0] q_d, r_d, f_d;
    logic       any_d;
    logic [5:0] q_f, r_f, f_f;
    logic       any_f;
    logic [5:0] q_s, r_s, f_s;
    logic       any_s;

    int n_chk = 0;
    int n_err = 0;

    ttl_hex_debounce dut (
        .CLK(CLK), .CLR(CLR), .A(A), .Q(q_d), .RISE(r_d), .FALL(f_d), .ANY(any_d)
    );
    ttl_hex_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_f (
        .CLK(CLK), .CLR(CLR), .A(A), .Q(q_f), .RISE(r_f), .FALL(f_f), .ANY(any_f)
    );
    ttl_hex_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(7)) dut_s (
        .CLK(CLK), .CLR(CLR), .A(A), .Q(q_s), .RISE(r_s), .FALL(f_s), .ANY(any_s)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_clr();
        CLR = 1'b1;
        #2;
        CLR = 1'b0;
    endtask

    initial begin
        // Reset held with all inputs high
        A = 6'h3F;
        for (int e = 1; e <= 5; e++) begin
            step();
            check("rst_q", 32'(q_d), 32'h0);
            check("rst_rise", 32'(r_d), 32'h0);
            check("rst_fall", 32'(f_d), 32'h0);
            check("rst_any", 32'(any_d), 32'h0);
        end
        CLR = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            check("rel_q", 32'(q_d), 32'((e >= 6) ? 6'h3F : 6'h00));
            check("rel_rise", 32'(r_d), 32'((e == 6) ? 6'h3F : 6'h00));
            check("rel_fall", 32'(f_d), 32'h0);
            check("rel_any", 32'(any_d), 32'(e == 6));
            check("d1s3_q", 32'(q_f), 32'((e >= 4) ? 6'h3F : 6'h00));
            check("d1s3_rise", 32'(r_f), 32'((e == 4) ? 6'h3F : 6'h00));
            check("d1s3_fall", 32'(f_f), 32'h0);
            check("d1s3_any", 32'(any_f), 32'(e == 4));
            check("d7_q", 32'(q_s), 32'((e >= 9) ? 6'h3F : 6'h00));
            check("d7_rise", 32'(r_s), 32'((e == 9) ? 6'h3F : 6'h00));
            check("d7_fall", 32'(f_s), 32'h0);
            check("d7_any", 32'(any_s), 32'(e == 9));
        end

        // Latency on channel 0
        A = 6'h00;
        pulse_clr();
        step();
        A = 6'h01;
        for (int e = 1; e <= 8; e++) begin
            step();
            check("lat_q0", 32'(q_d[0]), 32'(e >= 6));
            check("lat_rise", 32'(r_d), 32'((e == 6) ? 6'h01 : 6'h00));
            check("lat_fall", 32'(f_d), 32'h0);
        end

        // Glitch of 3 clocks on channel 2 is rejected
        A = 6'h00;
        pulse_clr();
        step();
        A = 6'h04;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 3) A = 6'h00;
            check("glt_q2", 32'(q_d[2]), 32'h0);
            check("glt_rise2", 32'(r_d[2]), 32'h0);
            check("glt_any", 32'(any_d), 32'h0);
        end

        // 4-clock pulse on channel 2 passes, then falls
        A = 6'h04;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e == 4) A = 6'h00;
            check("p4_q2", 32'(q_d[2]), 32'(e >= 6 && e < 10));
            check("p4_rise2", 32'(r_d[2]), 32'(e == 6));
            check("p4_fall2", 32'(f_d[2]), 32'(e == 10));
            check("p4_any", 32'(any_d), 32'(e == 6 || e == 10));
        end

        // Bounce on channel 5: toggle every clock, then hold high
        A = 6'h00;
        pulse_clr();
        step();
        for (int t = 0; t < 10; t++) begin
            A = (t % 2 == 0) ? 6'h20 : 6'h00;
            step();
            check("bnc_q5", 32'(q_d[5]), 32'h0);
            check("bnc_rise", 32'(r_d), 32'h0);
            check("bnc_fall", 32'(f_d), 32'h0);
        end
        A = 6'h20;
        for (int e = 1; e <= 8; e++) begin
            step();
            check("bnc_hold_q5", 32'(q_d[5]), 32'(e >= 6));
            check("bnc_hold_rise5", 32'(r_d[5]), 32'(e == 6));
            check("bnc_hold_fall5", 32'(f_d[5]), 32'h0);
        end

        // Simultaneous step on channels 0,2,4
        A = 6'h00;
        pulse_clr();
        step();
        A = 6'h15;
        for (int e = 1; e <= 7; e++) begin
            step();
            check("sim_q", 32'(q_d), 32'((e >= 6) ? 6'h15 : 6'h00));
            check("sim_rise", 32'(r_d), 32'((e == 6) ? 6'h15 : 6'h00));
            check("sim_any", 32'(any_d), 32'(e == 6));
        end

        // Reset mid-count discards partial progress
        A = 6'h00;
        pulse_clr();
        step();
        A = 6'h15;
        for (int e = 1; e <= 4; e++) begin
            step();
            check("mid_pre_q", 32'(q_d), 32'h0);
            check("mid_pre_any", 32'(any_d), 32'h0);
        end
        CLR = 1'b1;
        #1;
        check("mid_hold_q", 32'(q_d), 32'h0);
        check("mid_hold_rise", 32'(r_d), 32'h0);
        #1;
        CLR = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check("mid_q", 32'(q_d), 32'((e >= 6) ? 6'h15 : 6'h00));
            check("mid_rise", 32'(r_d), 32'((e == 6) ? 6'h15 : 6'h00));
            check("mid_any", 32'(any_d), 32'(e == 6));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ttl_hex_debounce.md
Name: ttl_hex_debounce

Overview:
- Six-channel input conditioner placed directly downstream of the hex inverter / Schmitt-trigger stage (7404/7414 Y outputs).
- Each channel's asynchronous, possibly bouncing level is synchronised to CLK and filtered with a per-channel stability counter.
- Per channel it produces a clean registered level and single-cycle rising/falling edge strobes for downstream counters and latches.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per channel; legal range >= 2.
- DEBOUNCE_CYCLES, 4, consecutive clocks the synchronised input must differ from Q before Q updates; legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, do not override.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  asynchronous, active-high reset.
- A  input  6  raw channel inputs, fed from inverter outputs Y1..Y6 (bit0=Y1 ... bit5=Y6).
- Q  output  6  debounced registered level per channel.
- RISE  output  6  one-CLK strobe when Q[i] goes 0->1.
- FALL  output  6  one-CLK strobe when Q[i] goes 1->0.
- ANY  output  1  registered OR of all RISE|FALL bits, asserted the same cycle as those strobes.

Behaviour:
- Reset:
  - CLR high asynchronously clears all synchroniser flops, counters, Q, RISE, FALL and ANY to 0.
  - Reset is held while CLR is high; the first update is at the first rising CLK edge after CLR falls.
- Synchroniser:
  - Per channel, a shift chain of SYNC_STAGES flops.
  - S[i] is the last stage; A[i] appears on S[i] SYNC_STAGES edges after it is first sampled.
- Debounce, per channel, evaluated every edge:
  - If S[i] == Q[i]: counter := 0.
  - Else if counter == DEBOUNCE_CYCLES-1: Q[i] := S[i], counter := 0, and RISE[i] or FALL[i] := 1 according to direction.
  - Else: counter := counter+1.
- Strobes:
  - RISE, FALL and ANY default to 0 each cycle; high for exactly one cycle per Q transition.
  - RISE[i] and FALL[i] are never high simultaneously.
- Latency:
  - A step on A[i] that is stable before edge 1 changes Q[i] at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - With defaults this is edge 6; the strobe is high during the cycle following edge 6.
- Glitch rejection:
  - Any excursion of S[i] lasting fewer than DEBOUNCE_CYCLES consecutive clocks resets the counter.
  - Q[i] does not change and no strobe is produced.
- DEBOUNCE_CYCLES = 1: Q[i] follows S[i] with one clock delay; a strobe fires on every S change.
- Channels are fully independent:
  - Simultaneous transitions on several channels produce simultaneous strobes.
  - ANY is a single pulse for that cycle.
- Reset mid-count: CLR discards the partial count; after release, counting restarts from 0.
- Counters saturate logically at DEBOUNCE_CYCLES-1 and cannot wrap.

Optional Feature:
- Macro: TTL_TIMING_EN.
- Defined: Q, RISE, FALL and ANY are driven through output buffers with min:typ:max delays #(0:9:15, 0:10:15), matching the 74LS gate timing used elsewhere in the library.
- Undefined: outputs are zero-delay continuous assigns from the registers; cycle behaviour is identical either way.

Test Plan:
- Reset: CLR=1 with A=6'h3F, toggle CLK 5 cycles -> Q=0, RISE=0, FALL=0, ANY=0 throughout; CLR falls -> Q=6'h3F at 6th edge after release, RISE=6'h3F for 1 cycle, ANY=1.
- Latency: defaults, A[0] 0->1 before edge 1 -> Q[0]=0 through edge 5, Q[0]=1 after edge 6, RISE[0]=1 for exactly one cycle, FALL=0.
- Glitch: A[2] high for 3 clocks then low -> Q[2] stays 0, RISE[2] and ANY never assert; a 4-clock pulse -> Q[2] rises, and after the input returns low Q[2] falls with FALL[2] one-cycle.
- Bounce: A[5] toggles every clock for 10 clocks, then holds 1 -> single RISE[5] pulse exactly 6 edges after the final transition, no FALL[5].
- Simultaneous/reset mid-count: A=6'h15 step -> RISE=6'h15 in one cycle, ANY single pulse; repeat with CLR pulsed at edge 4 -> no strobe, Q=0, then Q=6'h15 at 6th edge after CLR release.
- Parameter sweep: DEBOUNCE_CYCLES=1, SYNC_STAGES=3 -> Q follows A at edge 4; DEBOUNCE_CYCLES=7 -> edge 9.
